// File: rtl/ocm_bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : ocm_bus_initiator
//  Purpose  : Bus master for the OCM-style req/ack slot bus. Host-side
//             commands (read/write) are queued in a small FIFO and issued
//             one at a time as req/ack transactions. Each transaction
//             returns exactly one response pulse, which carries the read
//             data or a timeout status.
//  Ports    : clk, nreset           - clock, synchronous active-low reset
//             cmd_valid/ready/wrt/adr/data - host command push interface
//             rsp_valid/wrt/data/timeout   - one-cycle response pulse
//             busy                  - FIFO non-empty or transaction in flight
//             req/ack/wrt/adr/dbo/dbi      - slot bus master side
//  Revision : 1.0 - initial release
// ============================================================================
module ocm_bus_initiator #(
    parameter int FIFO_DEPTH = 4,   // power of two, 2..16
    parameter int TIMEOUT    = 255  // 1..255 cycles of req without ack
) (
    input  logic        clk,
    input  logic        nreset,
    // host command side
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wrt,
    input  logic [15:0] cmd_adr,
    input  logic [7:0]  cmd_data,
    // host response side
    output logic        rsp_valid,
    output logic        rsp_wrt,
    output logic [7:0]  rsp_data,
    output logic        rsp_timeout,
    output logic        busy,
    // slot bus
    output logic        req,
    input  logic        ack,
    output logic        wrt,
    output logic [15:0] adr,
    output logic [7:0]  dbo,
    input  logic [7:0]  dbi
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 25;                         // {wrt, adr[15:0], data[7:0]}

    localparam logic [CW-1:0] c_full_cnt = CW'(FIFO_DEPTH);
    localparam logic [7:0]    c_timeout  = 8'(TIMEOUT);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_gap  = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic [1:0]    state_q,  state_d;
    logic [7:0]    cnt_q,    cnt_d;
    logic          req_q,    req_d;
    logic          wrt_q,    wrt_d;
    logic [15:0]   adr_q,    adr_d;
    logic [7:0]    dbo_q,    dbo_d;

    logic          rsp_valid_q,   rsp_valid_d;
    logic          rsp_wrt_q,     rsp_wrt_d;
    logic [7:0]    rsp_data_q,    rsp_data_d;
    logic          rsp_timeout_q, rsp_timeout_d;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;

    assign w_full  = (count_q == c_full_cnt);
    assign w_empty = (count_q == '0);
    assign w_push  = cmd_valid && !w_full;
    assign w_head  = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_d         = req_q;
        wrt_d         = wrt_q;
        adr_d         = adr_q;
        dbo_d         = dbo_q;
        rsp_valid_d   = 1'b0;               // response is a single-cycle pulse
        rsp_wrt_d     = rsp_wrt_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        w_pop         = 1'b0;

        case (state_q)
            c_st_idle: begin
                if (!w_empty) begin
                    w_pop                = 1'b1;
                    {wrt_d, adr_d, dbo_d} = w_head;
                    req_d                = 1'b1;
                    cnt_d                = 8'd0;
                    state_d              = c_st_req;
                end
            end
            c_st_req: begin
                // ack takes priority over a timeout expiring on the same edge
                if (ack) begin
                    req_d         = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_wrt_d     = wrt_q;
                    rsp_timeout_d = 1'b0;
                    rsp_data_d    = wrt_q ? 8'h00 : dbi;
                    state_d       = c_st_gap;
                end else if (cnt_q == c_timeout) begin
                    req_d         = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_wrt_d     = wrt_q;
                    rsp_timeout_d = 1'b1;
                    rsp_data_d    = 8'hFF;
                    state_d       = c_st_gap;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            c_st_gap: begin
                // one guaranteed req-low cycle so the slave cannot re-trigger
                state_d = c_st_idle;
            end
            default: begin
                req_d   = 1'b0;
                state_d = c_st_idle;
            end
        endcase
    end

    // FIFO bookkeeping; push and pop may coincide at any level below full
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = {cmd_wrt, cmd_adr, cmd_data};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= c_st_idle;
            cnt_q         <= 8'd0;
            req_q         <= 1'b0;
            wrt_q         <= 1'b0;
            adr_q         <= 16'h0000;
            dbo_q         <= 8'h00;
            rsp_valid_q   <= 1'b0;
            rsp_wrt_q     <= 1'b0;
            rsp_data_q    <= 8'h00;
            rsp_timeout_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            wrt_q         <= wrt_d;
            adr_q         <= adr_d;
            dbo_q         <= dbo_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_wrt_q     <= rsp_wrt_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Storage array needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready   = !w_full;
    assign busy        = !w_empty || (state_q != c_st_idle);
    assign req         = req_q;
    assign wrt         = wrt_q;
    assign adr         = adr_q;
    assign dbo         = dbo_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_wrt     = rsp_wrt_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
`default_nettype wire
